vehicle_sensor_conditioner: RTL and testbench

VEHICLE_SENSOR_CONDITIONER -- requirements
Module: vehicle_sensor_conditioner

---
 rtl/vehicle_sensor_conditioner.sv | 169 ++++++++++++++++
 tb/tb_vehicle_sensor_conditioner.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/vehicle_sensor_conditioner.sv
// Loop-detector conditioner: two independent channels, each with a 2-flop
// synchronizer, a debounce/min-on FSM and a stuck-detector fault latch.

module vsc_channel #(
  parameter int DEB_CYCLES  = 4,
  parameter int MIN_ON      = 8,
  parameter int STUCK_LIMIT = 1024
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_s,
  output logic o_event,
  output logic o_fault
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int OW = $clog2(MIN_ON + 1);
  localparam int SW = $clog2(STUCK_LIMIT + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [OW-1:0] ON_LAST  = OW'(MIN_ON - 1);
  localparam logic [SW-1:0] STK_LAST = SW'(STUCK_LIMIT - 1);

  typedef enum logic [1:0] {OFF, ARM, ON, REL} state_t;

  logic          r_s1, r_s2;
  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [OW-1:0] r_on, w_on;
  logic [SW-1:0] r_stk, w_stk;
  logic          r_fault, w_fault;
  logic          r_s, w_s;
  logic          r_evt, w_evt;

  // Next-state, counters and registered-output inputs for one channel
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_stk   = r_stk;
    w_fault = r_fault;
    // on-time runs in both high states and saturates so it never wraps
    w_on    = r_on;
    if ((r_state == ON || r_state == REL) && r_on != ON_LAST)
      w_on = r_on + 1'b1;
    case (r_state)
      OFF: begin
        if (r_s2) begin
          w_state = ARM;
          w_cnt   = CW'(1);
        end
      end
      ARM: begin
        if (!r_s2) begin
          w_state = OFF;
          w_cnt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state = ON;
          w_on    = '0;
          w_stk   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ON: begin
        if (!r_s2) begin
          w_state = REL;
          w_cnt   = CW'(1);
          w_stk   = '0;
        end else begin
          if (r_stk == STK_LAST) w_fault = 1'b1;
          else                   w_stk   = r_stk + 1'b1;
        end
      end
      REL: begin
        if (r_s2) begin
          w_state = ON;
          w_cnt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          // debounced release, but only once the minimum on-time is served
          if (r_on >= ON_LAST) begin
            w_state = OFF;
            w_cnt   = '0;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = OFF;
    endcase
    // a faulted channel demands service permanently; Sx cannot fall while
    // the fault is set, so the rising-edge event never fires from forcing
    w_s   = (w_state == ON) || (w_state == REL) || w_fault;
    w_evt = w_s & ~r_s;
  end

  // Synchronizer, FSM state, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= OFF;
      r_cnt   <= '0;
      r_on    <= '0;
      r_stk   <= '0;
      r_fault <= 1'b0;
      r_s     <= 1'b0;
      r_evt   <= 1'b0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_on    <= w_on;
      r_stk   <= w_stk;
      r_fault <= w_fault;
      r_s     <= w_s;
      r_evt   <= w_evt;
    end
  end

  assign o_s     = r_s;
  assign o_event = r_evt;
  assign o_fault = r_fault;
endmodule

module vehicle_sensor_conditioner #(
  parameter int DEB_CYCLES  = 4,
  parameter int MIN_ON      = 8,
  parameter int STUCK_LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_a,
  input  logic raw_b,
  output logic Sa,
  output logic Sb,
  output logic event_a,
  output logic event_b,
  output logic fault_a,
  output logic fault_b
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0] w_raw, w_s, w_evt, w_fault;

  assign w_raw = {raw_b, raw_a};

  // lane 0 = road A, lane 1 = road B
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    vsc_channel #(
      .DEB_CYCLES (DEB_CYCLES),
      .MIN_ON     (MIN_ON),
      .STUCK_LIMIT(STUCK_LIMIT)
    ) u_ch (
      .i_clk  (clk),
      .i_reset(reset),
      .i_raw  (w_raw[g]),
      .o_s    (w_s[g]),
      .o_event(w_evt[g]),
      .o_fault(w_fault[g])
    );
  end

  assign Sa      = w_s[0];
  assign Sb      = w_s[1];
  assign event_a = w_evt[0];
  assign event_b = w_evt[1];
  assign fault_a = w_fault[0];
  assign fault_b = w_fault[1];
endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed bench for vehicle_sensor_conditioner (DEB=4, MIN_ON=8, STUCK=32).
// "Edge k" is the k-th rising edge after the stimulus change; outputs are
// sampled 1 time unit after each edge, inputs change at that same point.

module tb_vehicle_sensor_conditioner;
  logic clk = 1'b0;
  logic reset, raw_a, raw_b;
  logic Sa, Sb, event_a, event_b, fault_a, fault_b;
  int   n_chk = 0;
  int   n_err = 0;

  vehicle_sensor_conditioner #(
    .DEB_CYCLES (4),
    .MIN_ON     (8),
    .STUCK_LIMIT(32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .Sa     (Sa),
    .Sb     (Sb),
    .event_a(event_a),
    .event_b(event_b),
    .fault_a(fault_a),
    .fault_b(fault_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {fault_b, fault_a, event_b, event_a, Sb, Sa};
  endfunction

  initial begin
    reset = 1'b1; raw_a = 1'b0; raw_b = 1'b0;
    step(3);
    chk("reset_outs", 32'(outs()), 32'd0);
    reset = 1'b0;
    step(2);
    chk("idle_outs", 32'(outs()), 32'd0);

    // steady high on A: demand after edge 5, single event, B untouched
    raw_a = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step(1);
      chk($sformatf("hold_Sa_e%0d", k), 32'(Sa), 32'(k >= 5));
      chk($sformatf("hold_evA_e%0d", k), 32'(event_a), 32'(k == 5));
      chk($sformatf("hold_B_e%0d", k), 32'({Sb, event_b}), 32'd0);
    end
    raw_a = 1'b0;
    step(20);
    chk("hold_release", 32'(Sa), 32'd0);

    // 3-sample glitch never asserts
    raw_a = 1'b1;
    step(3);
    raw_a = 1'b0;
    for (int k = 3; k < 14; k++) begin
      step(1);
      chk($sformatf("glitch_e%0d", k), 32'({Sa, event_a}), 32'd0);
    end

    // 5-sample pulse: held high by min-on for exactly edges 5..12
    for (int k = 0; k < 16; k++) begin
      raw_a = (k <= 4);
      step(1);
      chk($sformatf("minon_Sa_e%0d", k), 32'(Sa), 32'(k >= 5 && k <= 12));
    end
    step(5);

    // short dropout while on: no release, no second event
    raw_a = 1'b1;
    step(10);
    chk("drop_pre_Sa", 32'(Sa), 32'd1);
    raw_a = 1'b0;
    step(2);
    raw_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk($sformatf("drop_e%0d", k), 32'({Sa, event_a}), 32'b10);
    end
    raw_a = 1'b0;
    step(30);
    chk("drop_release", 32'(Sa), 32'd0);

    // stuck B: ON at edge 5, 32 ON cycles -> fault after edge 37, sticky
    raw_b = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step(1);
      if (k == 36) chk("stuck_pre", 32'(fault_b), 32'd0);
      if (k == 37) chk("stuck_set", 32'(fault_b), 32'd1);
    end
    chk("stuck_A_clean", 32'({Sa, fault_a}), 32'd0);
    raw_b = 1'b0;
    step(20);
    chk("stuck_forced_Sb", 32'(Sb), 32'd1);
    chk("stuck_sticky", 32'(fault_b), 32'd1);
    chk("stuck_no_event", 32'(event_b), 32'd0);
    reset = 1'b1;
    step(1);
    chk("stuck_reset", 32'(outs()), 32'd0);
    reset = 1'b0;
    step(3);
    chk("post_reset", 32'(outs()), 32'd0);

    // simultaneous rise, then reset mid-ON and recovery
    raw_a = 1'b1; raw_b = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step(1);
      chk($sformatf("both_ev_e%0d", k), 32'({event_b, event_a}), (k == 5) ? 32'b11 : 32'b00);
    end
    step(2);
    reset = 1'b1;
    step(1);
    chk("mid_reset_Sa", 32'(Sa), 32'd0);
    reset = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      step(1);
      chk($sformatf("recover_Sa_j%0d", j), 32'(Sa), 32'(j >= 6));
      chk($sformatf("recover_evA_j%0d", j), 32'(event_a), 32'(j == 6));
    end
    raw_a = 1'b0; raw_b = 1'b0;
    step(20);
    chk("final_idle", 32'(outs()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
